// File: rtl/tach_pkg.sv
// Shared constants and helpers for the multi-channel tachometer.
package tach_pkg;

  localparam int MS_PER_MIN = 60000;
  localparam int PHONE_W    = 8;
  localparam int SYNC_DEPTH = 2;

  function automatic int unsigned gate_cyc(
    input int unsigned clk_hz,
    input int unsigned gate_ms
  );
    return clk_hz / 1000 * gate_ms;
  endfunction

endpackage

// File: rtl/tach_edge_sync.sv
// One-channel synchroniser followed by a rising-edge detector.
module tach_edge_sync
  import tach_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
      prev   <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign rise = sync_q[SYNC_DEPTH-1] & ~prev;

endmodule

// File: rtl/tach_meter.sv
// Gated-window multi-channel tachometer producing rpm per channel.
// Optional stall detection is built when TACH_STALL_EN is defined.
module tach_meter
  import tach_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CLK_HZ         = 50000000,
  parameter int GATE_MS        = 1000,
  parameter int PULSES_PER_REV = 80,
  parameter int RPM_W          = 16,
  parameter int STALL_MS       = 250
) (
  input  logic                      clk50M,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         blips,
  output logic [NUM_CH*RPM_W-1:0]   rpm,
  output logic [NUM_CH*PHONE_W-1:0] rpmPhone,
  output logic                      rpm_valid,
  output logic [NUM_CH-1:0]         sat,
  output logic [NUM_CH-1:0]         stalled
);

  localparam int unsigned GATE_CYC = gate_cyc(CLK_HZ, GATE_MS);
  localparam int GATE_W = $clog2(GATE_CYC);
  localparam int CNT_W  = $clog2(GATE_CYC / 2 + 1);
  localparam int PROD_W = CNT_W + 17;
  localparam int unsigned DIV = PULSES_PER_REV * GATE_MS;

  logic [NUM_CH-1:0] rise;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    tach_edge_sync u_sync (
      .clk  (clk50M),
      .reset(reset),
      .din  (blips[g]),
      .rise (rise[g])
    );
  end

  logic [GATE_W-1:0] gate;
  logic              win_end;
  logic              conv;
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [CNT_W-1:0]  held [NUM_CH];

  assign win_end = gate == GATE_W'(GATE_CYC - 1);

  // An edge on the window-end cycle belongs to the next window.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      gate <= '0;
      conv <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt[ch]  <= '0;
        held[ch] <= '0;
      end
    end else begin
      gate <= win_end ? '0 : gate + GATE_W'(1);
      conv <= win_end;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (win_end) begin
          held[ch] <= cnt[ch];
          cnt[ch]  <= rise[ch] ? CNT_W'(1) : '0;
        end else if (rise[ch] && cnt[ch] != '1) begin
          cnt[ch] <= cnt[ch] + CNT_W'(1);
        end
      end
    end
  end

  logic [PROD_W-1:0]  prod  [NUM_CH];
  logic [RPM_W-1:0]   clamp [NUM_CH];
  logic [PHONE_W-1:0] phone [NUM_CH];
  logic [NUM_CH-1:0]  over;

  always_comb begin
    over = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      prod[ch]  = PROD_W'(held[ch]) * PROD_W'(MS_PER_MIN)
                / PROD_W'(DIV);
      over[ch]  = |(prod[ch] >> RPM_W);
      clamp[ch] = over[ch] ? '1 : RPM_W'(prod[ch]);
      phone[ch] = |(clamp[ch] >> (PHONE_W + 1)) ? '1
                : PHONE_W'(clamp[ch] >> 1);
    end
  end

`ifdef TACH_STALL_EN
  localparam int unsigned STALL_CYC = STALL_MS * (CLK_HZ / 1000);
  localparam int TMR_W = $clog2(STALL_CYC + 1);

  logic [TMR_W-1:0] tmr [NUM_CH];

  always_ff @(posedge clk50M) begin
    if (reset) begin
      stalled <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) tmr[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (rise[ch]) begin
          tmr[ch]     <= '0;
          stalled[ch] <= 1'b0;
        end else if (tmr[ch] == TMR_W'(STALL_CYC - 1)) begin
          stalled[ch] <= 1'b1;
        end else begin
          tmr[ch] <= tmr[ch] + TMR_W'(1);
        end
      end
    end
  end
`else
  assign stalled = '0;
`endif

  always_ff @(posedge clk50M) begin
    if (reset) begin
      rpm       <= '0;
      rpmPhone  <= '0;
      rpm_valid <= 1'b0;
      sat       <= '0;
    end else begin
      rpm_valid <= conv;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (conv) begin
          rpm[ch*RPM_W +: RPM_W]        <= clamp[ch];
          rpmPhone[ch*PHONE_W +: PHONE_W] <= phone[ch];
          sat[ch]                       <= over[ch];
        end
`ifdef TACH_STALL_EN
        if (stalled[ch]) begin
          rpm[ch*RPM_W +: RPM_W]        <= '0;
          rpmPhone[ch*PHONE_W +: PHONE_W] <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_tach_meter.sv
// Randomised scoreboard bench for tach_meter (default build).
module tb_tach_meter;

  localparam int NCH = 2;
  localparam int CLK = 1000000;
  localparam int GMS = 1;
  localparam int PPR = 80;
  localparam int RW  = 16;
  localparam int PW  = 8;
  localparam int G   = CLK / 1000 * GMS;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NCH-1:0]      blips = '0;
  logic [NCH*RW-1:0]   rpm;
  logic [NCH*PW-1:0]   rpm_phone;
  logic                rpm_valid;
  logic [NCH-1:0]      sat;
  logic [NCH-1:0]      stalled;

  tach_meter #(
    .NUM_CH(NCH), .CLK_HZ(CLK), .GATE_MS(GMS),
    .PULSES_PER_REV(PPR), .RPM_W(RW), .STALL_MS(250)
  ) dut (
    .clk50M(clk), .reset(reset), .blips(blips),
    .rpm(rpm), .rpmPhone(rpm_phone), .rpm_valid(rpm_valid),
    .sat(sat), .stalled(stalled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             at;
    longint         r  [NCH];
    longint         ph [NCH];
    logic [NCH-1:0] s;
  } exp_t;

  exp_t           q[$];
  int             checks = 0;
  int             errors = 0;
  int             j = 0;
  int             cur_w = 0;
  int             wcnt [NCH];
  logic [NCH-1:0] prev_v = '0;
  int             pe = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected result of a finished window from its edge counts.
  task automatic push_window(int w);
    exp_t   e;
    longint raw;
    e.at = (w + 1) * G + 1;
    for (int c = 0; c < NCH; c++) begin
      raw     = longint'(wcnt[c]) * 60000 / (PPR * GMS);
      e.s[c]  = raw > 65535;
      e.r[c]  = raw > 65535 ? 65535 : raw;
      e.ph[c] = e.r[c] / 2 > 255 ? 255 : e.r[c] / 2;
    end
    q.push_back(e);
  endtask

  // Level v is seen at posedge j; its rising edge counts at edge j+2.
  task automatic drive(logic [NCH-1:0] v);
    int w;
    blips = v;
    w = (j + 3) / G;
    if (w != cur_w) begin
      push_window(cur_w);
      foreach (wcnt[c]) wcnt[c] = 0;
      cur_w = w;
    end
    for (int c = 0; c < NCH; c++)
      if (v[c] && !prev_v[c]) wcnt[c]++;
    prev_v = v;
    j++;
    @(negedge clk);
  endtask

  task automatic run_window(int n0, int n1, bit bnd);
    logic [NCH-1:0] v;
    int n [NCH];
    n[0] = n0;
    n[1] = n1;
    for (int k = 0; k < G; k++) begin
      for (int c = 0; c < NCH; c++)
        v[c] = k >= 10 && k < 10 + 2 * n[c] && (k - 10) % 2 == 0;
      if (bnd && k >= G - 3) v[0] = 1'b1;
      drive(v);
    end
  endtask

  task automatic rand_window();
    for (int k = 0; k < G; k++) drive(NCH'($urandom));
  endtask

  task automatic do_reset(int hold);
    reset = 1'b1;
    blips = '0;
    @(negedge clk);
    chk("reset_rpm", 64'(rpm), 0);
    chk("reset_phone", 64'(rpm_phone), 0);
    chk("reset_valid", 64'(rpm_valid), 0);
    chk("reset_sat", 64'(sat), 0);
    chk("reset_stalled", 64'(stalled), 0);
    repeat (hold - 1) @(negedge clk);
    reset = 1'b0;
    j = 0;
    cur_w = 0;
    prev_v = '0;
    foreach (wcnt[c]) wcnt[c] = 0;
    q.delete();
  endtask

  always @(posedge clk) begin
    if (reset) pe = 0;
    else pe++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rpm_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got 1 expected 0 at cycle %0d", pe);
      end else begin
        e = q.pop_front();
        chk("valid_time", 64'(pe), 64'(e.at));
        for (int c = 0; c < NCH; c++) begin
          chk($sformatf("rpm[%0d]", c), 64'(rpm[c*RW +: RW]), 64'(e.r[c]));
          chk($sformatf("phone[%0d]", c),
              64'(rpm_phone[c*PW +: PW]), 64'(e.ph[c]));
          chk($sformatf("sat[%0d]", c), 64'(sat[c]), 64'(e.s[c]));
        end
        chk("stalled", 64'(stalled), 0);
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset(3);
    run_window(4, 0, 1'b0);
    run_window(100, 2, 1'b0);
    run_window(5, 3, 1'b1);
    run_window(0, 0, 1'b0);
    for (int k = 0; k < 30; k++)
      drive({1'b0, k >= 10 && (k - 10) % 2 == 0});
    do_reset(2);
    run_window(3, 7, 1'b0);
    for (int i = 0; i < 6; i++)
      run_window($urandom_range(0, 480), $urandom_range(0, 480),
                 1'($urandom));
    rand_window();
    rand_window();
    repeat (G + 5) drive('0);
    chk("pending", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tach_meter.md
TACH_METER -- requirements
Module: tach_meter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent tachometer channels (1..8).
REQ-002 SHALL have parameter CLK_HZ, default 50000000: input clock frequency in Hz.
REQ-003 SHALL have parameter GATE_MS, default 1000: measurement window length in ms (1..1000).
REQ-004 SHALL have parameter PULSES_PER_REV, default 80: blips per output-shaft revolution (poles x gear ratio).
REQ-005 SHALL have parameter RPM_W, default 16: width of each rpm result.
REQ-006 SHALL have parameter STALL_MS, default 250: no-edge timeout in ms (used only with TACH_STALL_EN).
REQ-007 SHALL have port clk50M, input, 1: sole clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port blips, input, NUM_CH: asynchronous motor-controller pulse inputs, one per channel.
REQ-010 SHALL have port rpm, output, NUM_CH x RPM_W: latest registered rpm per channel.
REQ-011 SHALL have port rpmPhone, output, NUM_CH x 8: per-channel phone-link value.
REQ-012 SHALL have port rpm_valid, output, 1: one-cycle strobe when rpm updates at window end.
REQ-013 SHALL have port sat, output, NUM_CH: sticky flag, channel result saturated in the last window.
REQ-014 SHALL have port stalled, output, NUM_CH: channel in stall state (constant 0 without TACH_STALL_EN).

Function
REQ-015 Each blips bit SHALL pass a 2-flop synchroniser, then rising-edge detect; one count per rising edge, 3-cycle input-to-count latency.
REQ-016 A shared gate counter SHALL count 0..GATE_CYC-1, GATE_CYC = CLK_HZ/1000*GATE_MS, wrapping to 0.
REQ-017 Per-channel edge counters SHALL be sized for max GATE_CYC/2 edges and saturate at all-ones, never wrap.
REQ-018 On the cycle gate counter = GATE_CYC-1 (window end), each channel count SHALL be latched and its counter cleared.
REQ-019 An edge detected on the window-end cycle SHALL be counted in the new window (counter loads 1, not 0).
REQ-020 Latched count SHALL convert as rpm = count*60000/(PULSES_PER_REV*GATE_MS), integer truncation; divisor is constant, computed at elaboration.
REQ-021 Conversion SHALL be one pipeline stage; rpm and rpm_valid update exactly 1 cycle after window end, rpm_valid high for 1 cycle.
REQ-022 Results exceeding 2^RPM_W-1 SHALL clamp to 2^RPM_W-1 and set sat for that channel until the next update without saturation.
REQ-023 rpmPhone SHALL equal rpm>>1, clamped to 255, registered in the same cycle as rpm.
REQ-024 rpm SHALL hold its value between window ends; no intermediate values visible.

Reset
REQ-025 While reset is high at a clock edge: gate counter, edge counters, synchronisers, rpm, rpmPhone, rpm_valid, sat, stalled SHALL all become 0.
REQ-026 Reset mid-window SHALL discard the partial count; first rpm_valid after release SHALL occur GATE_CYC+1 cycles after the first non-reset edge.

Configuration
REQ-027 Macro TACH_STALL_EN defined: per-channel timer counts cycles since last edge; at STALL_MS*CLK_HZ/1000 cycles, stalled set, that channel's rpm and rpmPhone forced 0 the next cycle without waiting for window end.
REQ-028 With TACH_STALL_EN, stalled SHALL clear on the channel's next detected edge; rpm resumes updating at the next window end.
REQ-029 TACH_STALL_EN undefined: no stall timers synthesised; stalled tied 0; rpm changes only at window end.

Structure
REQ-030 Package tach_pkg SHALL hold the ms-per-minute constant (60000), phone width (8), synchroniser depth (2), and a function computing GATE_CYC.
REQ-031 Sub-module tach_edge_sync (synchroniser + rising-edge detector, 1 channel) SHALL be instantiated NUM_CH times via generate.

Verification
REQ-032 GATE_MS=1, defaults otherwise: 4 edges on ch0 in window -> rpm[0]=3000, rpmPhone[0]=255, rpm_valid 1 cycle at window end +1.
REQ-033 GATE_MS=1: 100 edges ch0, 2 edges ch1 same window -> rpm[0]=65535 with sat[0]=1, rpm[1]=1500 with sat[1]=0.
REQ-034 Edge arriving exactly at gate counter GATE_CYC-1 -> excluded from latched count, next window count starts at 1.
REQ-035 Reset asserted at mid-window after 10 edges -> all outputs 0 next cycle; post-release window reports only post-release edges.
REQ-036 TACH_STALL_EN, STALL_MS=1, GATE_MS=10: edges stop after rpm=nonzero -> stalled=1 and rpm=0 within 50001 cycles of last edge; one new edge clears stalled.
